// File: rtl/eqed_ctrl_pkg.sv
// Shared types and constants for the EQED single-bit-flip injection controller.
// Holds the run FSM encoding, MISR polynomial/seed and the observe-bit placement.
package eqed_ctrl_pkg;

    localparam int unsigned NUM_FF = 8;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CYC_W  = 10;
    localparam int unsigned OBS_W  = 3;
    localparam int unsigned MISR_W = 6;
    localparam int unsigned IDX_W  = $clog2(NUM_FF);

    localparam logic [MISR_W-1:0] MISR_SEED = 6'h01;
    localparam logic [MISR_W-1:0] MISR_POLY = 6'b110000;

    // Signature bit that each observed output (x, y, z) is folded into
    localparam int unsigned OBS_POS [OBS_W] = '{0, 2, 4};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } state_e;

    function automatic logic [MISR_W-1:0] misr_spread(input logic [OBS_W-1:0] obs);
        logic [MISR_W-1:0] v;
        v = '0;
        for (int j = 0; j < int'(OBS_W); j++) begin
            v[OBS_POS[j]] = obs[j];
        end
        return v;
    endfunction

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                    input logic [OBS_W-1:0]  obs);
        logic fb;
        fb = ^(sig & MISR_POLY);
        return {sig[MISR_W-2:0], fb} ^ misr_spread(obs);
    endfunction

endpackage

// File: rtl/eqed_misr.sv
// Multiple-input signature register: reloads the seed on load_i and absorbs
// one observed-output sample per cycle while en_i is high.
module eqed_misr
    import eqed_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [OBS_W-1:0]  obs_i,
    output logic [MISR_W-1:0] sig_o
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = MISR_SEED;
        end else if (en_i) begin
            sig_d = misr_step(sig_q, obs_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/eqed_inject_ctrl.sv
// Run-level EQED campaign controller: issues one single-cycle flip select, folds the
// observed outputs into a MISR and flags a golden mismatch. EQED_SKIP_MASK_EN adds skip_mask/skipped.
module eqed_inject_ctrl
    import eqed_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  target_idx,
    input  logic [CYC_W-1:0]  inject_cycle,
    input  logic [CYC_W-1:0]  observe_len,
    input  logic [MISR_W-1:0] golden_sig,
    input  logic [OBS_W-1:0]  obs_in,
`ifdef EQED_SKIP_MASK_EN
    input  logic [NUM_FF-1:0] skip_mask,
    output logic              skipped,
`endif
    output logic [NUM_FF-1:0] eqed_sel,
    output logic              busy,
    output logic              injected,
    output logic              done,
    output logic              detected,
    output logic [MISR_W-1:0] sig_out,
    output logic [CYC_W-1:0]  cycle_count
);

    state_e            state_q;
    logic [SEL_W-1:0]  target_q;
    logic [CYC_W-1:0]  inject_q;
    logic [CYC_W-1:0]  len_q;
    logic [MISR_W-1:0] golden_q;
    logic [CYC_W-1:0]  cycle_q;
    logic              busy_q;
    logic              injected_q;
    logic              done_q;
    logic              detected_q;
`ifdef EQED_SKIP_MASK_EN
    logic              skipped_q;
    logic              skip_hit_c;
`endif

    logic accept_c;
    logic target_ok_c;
    logic fire_c;

    // A start arriving alongside the done pulse is deliberately dropped
    assign accept_c    = (state_q == IDLE) && start && !done_q;
    assign target_ok_c = target_q < SEL_W'(NUM_FF);
    assign fire_c      = (state_q == RUN) && (cycle_q == inject_q) && target_ok_c && !injected_q;

    // Decoded straight from registers so an async reset removes the flip immediately
    assign eqed_sel = fire_c ? (NUM_FF'(1) << target_q[IDX_W-1:0]) : '0;

`ifdef EQED_SKIP_MASK_EN
    assign skip_hit_c = (target_idx < SEL_W'(NUM_FF)) && skip_mask[target_idx[IDX_W-1:0]];
`endif

    eqed_misr u_misr (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept_c),
        .en_i   (state_q == RUN),
        .obs_i  (obs_in),
        .sig_o  (sig_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            target_q   <= '0;
            inject_q   <= '0;
            len_q      <= '0;
            golden_q   <= '0;
            cycle_q    <= '0;
            busy_q     <= 1'b0;
            injected_q <= 1'b0;
            done_q     <= 1'b0;
            detected_q <= 1'b0;
`ifdef EQED_SKIP_MASK_EN
            skipped_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        target_q   <= target_idx;
                        inject_q   <= inject_cycle;
                        len_q      <= (observe_len == '0) ? CYC_W'(1) : observe_len;
                        golden_q   <= golden_sig;
                        cycle_q    <= CYC_W'(1);
                        busy_q     <= 1'b1;
                        injected_q <= 1'b0;
                        detected_q <= 1'b0;
                        state_q    <= RUN;
`ifdef EQED_SKIP_MASK_EN
                        skipped_q  <= skip_hit_c;
                        if (skip_hit_c) begin
                            state_q <= CHECK;
                        end
`endif
                    end
                end
                RUN: begin
                    cycle_q <= cycle_q + CYC_W'(1);
                    if (fire_c) begin
                        injected_q <= 1'b1;
                    end
                    if (cycle_q == len_q) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    detected_q <= (sig_out != golden_q);
`ifdef EQED_SKIP_MASK_EN
                    if (skipped_q) begin
                        detected_q <= 1'b0;
                    end
`endif
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign injected    = injected_q;
    assign done        = done_q;
    assign detected    = detected_q;
    assign cycle_count = cycle_q;
`ifdef EQED_SKIP_MASK_EN
    assign skipped     = skipped_q;
`endif

endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// Self-checking bench for eqed_inject_ctrl: directed scenarios plus randomized runs
// compared against an arithmetic signature/flip model of the campaign rules.
module tb_eqed_inject_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] target_idx;
    logic [9:0] inject_cycle;
    logic [9:0] observe_len;
    logic [5:0] golden_sig;
    logic [2:0] obs_in;
    logic [7:0] eqed_sel;
    logic       busy, injected, done, detected;
    logic [5:0] sig_out;
    logic [9:0] cycle_count;
`ifdef EQED_SKIP_MASK_EN
    logic [7:0] skip_mask;
    logic       skipped;
`endif

    int checks = 0;
    int errors = 0;

    // Results captured by do_run for the scenario tasks to judge
    int         r_done_edge;
    bit         r_timeout;
    int         r_sel_cycles;
    logic [7:0] r_sel_val;
    int         r_sel_cnt;
    logic [2:0] r_obs[$];
    logic       r_det, r_inj, r_busy;
    logic [5:0] r_sig;

    eqed_inject_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .target_idx   (target_idx),
        .inject_cycle (inject_cycle),
        .observe_len  (observe_len),
        .golden_sig   (golden_sig),
        .obs_in       (obs_in),
`ifdef EQED_SKIP_MASK_EN
        .skip_mask    (skip_mask),
        .skipped      (skipped),
`endif
        .eqed_sel     (eqed_sel),
        .busy         (busy),
        .injected     (injected),
        .done         (done),
        .detected     (detected),
        .sig_out      (sig_out),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    // Signature after absorbing the first n recorded samples, in plain integer arithmetic
    function automatic logic [5:0] model_sig(input int n);
        int s;
        int o;
        int fb;
        s = 1;
        for (int i = 0; i < n; i++) begin
            o  = int'(r_obs[i]);
            fb = ((s >> 4) ^ (s >> 5)) & 1;
            s  = ((s << 1) & 63) | fb;
            s  = s ^ ((o & 1) | (((o >> 1) & 1) << 2) | (((o >> 2) & 1) << 4));
        end
        return 6'(s);
    endfunction

    function automatic bit model_flips(input int tgt, input int inj, input int eff_len);
        return (tgt < 8) && (inj >= 1) && (inj <= eff_len);
    endfunction

    task automatic do_run(input logic [3:0] tgt, input logic [9:0] inj, input logic [9:0] len,
                          input logic [5:0] gold, input bit rnd_obs, input int poke_edge);
        r_obs.delete();
        r_sel_cycles = 0;
        r_sel_val    = '0;
        r_sel_cnt    = 0;
        r_done_edge  = 0;
        r_timeout    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        target_idx   = tgt;
        inject_cycle = inj;
        observe_len  = len;
        golden_sig   = gold;
        obs_in       = '0;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 1100; e++) begin
            obs_in = rnd_obs ? 3'($urandom) : 3'b000;
            r_obs.push_back(obs_in);
            if (eqed_sel != '0) begin
                r_sel_cycles++;
                r_sel_val = eqed_sel;
                r_sel_cnt = int'(cycle_count);
            end
            start = (e == poke_edge);
            @(posedge clk);
            #1;
            if (done) begin
                r_done_edge = e;
                r_timeout   = 1'b0;
                break;
            end
        end
        start  = 1'b0;
        r_det  = detected;
        r_inj  = injected;
        r_sig  = sig_out;
        r_busy = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (eqed_sel !== 8'h00) begin errors++; $display("FAIL reset_sel got %h want 00", eqed_sel); end
        checks++; if ({busy, injected, done, detected} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {busy, injected, done, detected}); end
        checks++; if (sig_out !== 6'h01) begin errors++; $display("FAIL reset_sig got %h want 01", sig_out); end
        checks++; if (cycle_count !== 10'd0) begin errors++; $display("FAIL reset_cycle got %0d want 0", cycle_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_signature();
        do_run(4'd8, 10'd3, 10'd5, 6'h21, 1'b0, 0);
        checks++; if (r_done_edge !== 6) begin errors++; $display("FAIL sig_done_edge got %0d want 6", r_done_edge); end
        checks++; if (r_sel_cycles !== 0) begin errors++; $display("FAIL sig_no_flip got %0d want 0", r_sel_cycles); end
        checks++; if (r_sig !== 6'h21) begin errors++; $display("FAIL sig_value got %h want 21", r_sig); end
        checks++; if ({r_det, r_inj, r_busy} !== 3'b000) begin errors++; $display("FAIL sig_flags got %b want 000", {r_det, r_inj, r_busy}); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sig_done_pulse got %b want 0", done); end
    endtask

    task automatic test_flip_timing();
        do_run(4'd5, 10'd4, 10'd5, 6'h00, 1'b1, 0);
        checks++; if (r_sel_cycles !== 1) begin errors++; $display("FAIL flip_count got %0d want 1", r_sel_cycles); end
        checks++; if (r_sel_val !== 8'h20) begin errors++; $display("FAIL flip_sel got %h want 20", r_sel_val); end
        checks++; if (r_sel_cnt !== 4) begin errors++; $display("FAIL flip_cycle got %0d want 4", r_sel_cnt); end
        checks++; if (r_inj !== 1'b1) begin errors++; $display("FAIL flip_injected got %b want 1", r_inj); end
        checks++; if (r_sig !== model_sig(5)) begin errors++; $display("FAIL flip_sig got %h want %h", r_sig, model_sig(5)); end
        checks++; if (r_det !== (model_sig(5) != 6'h00)) begin errors++; $display("FAIL flip_det got %b want %b", r_det, model_sig(5) != 6'h00); end
    endtask

    task automatic test_mismatch();
        do_run(4'd8, 10'd3, 10'd5, 6'h20, 1'b0, 0);
        checks++; if (r_det !== 1'b1) begin errors++; $display("FAIL mm_detected got %b want 1", r_det); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({detected, sig_out} !== {1'b1, 6'h21}) begin errors++; $display("FAIL mm_hold got %b/%h want 1/21", detected, sig_out); end
        @(negedge clk);
        target_idx  = 4'd9;
        observe_len = 10'd2;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if ({detected, busy, cycle_count} !== {1'b0, 1'b1, 10'd1}) begin errors++; $display("FAIL mm_restart got %b/%b/%0d want 0/1/1", detected, busy, cycle_count); end
        r_timeout = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (done) begin r_timeout = 1'b0; break; end
        end
        checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL mm_restart_done got timeout want done"); end
    endtask

    task automatic test_out_of_window();
        do_run(4'd2, 10'd0, 10'd5, 6'h00, 1'b1, 0);
        checks++; if ({r_sel_cycles != 0, r_inj} !== 2'b00) begin errors++; $display("FAIL oow_zero got %0d/%b want 0/0", r_sel_cycles, r_inj); end
        do_run(4'd2, 10'd6, 10'd5, 6'h00, 1'b1, 0);
        checks++; if ({r_sel_cycles != 0, r_inj} !== 2'b00) begin errors++; $display("FAIL oow_late got %0d/%b want 0/0", r_sel_cycles, r_inj); end
        do_run(4'd1, 10'd1, 10'd0, 6'h00, 1'b1, 0);
        checks++; if (r_done_edge !== 2) begin errors++; $display("FAIL len0_done_edge got %0d want 2", r_done_edge); end
        checks++; if ({r_sel_val, r_inj} !== {8'h02, 1'b1}) begin errors++; $display("FAIL len0_flip got %h/%b want 02/1", r_sel_val, r_inj); end
    endtask

    task automatic test_start_during_run();
        int extra_done;
        int extra_busy;
        do_run(4'd8, 10'd0, 10'd5, 6'h15, 1'b1, 2);
        checks++; if (r_done_edge !== 6) begin errors++; $display("FAIL poke_done_edge got %0d want 6", r_done_edge); end
        checks++; if (r_sig !== model_sig(5)) begin errors++; $display("FAIL poke_sig got %h want %h", r_sig, model_sig(5)); end
        extra_done = 0;
        extra_busy = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        checks++; if ({extra_done, extra_busy} !== {32'd0, 32'd0}) begin errors++; $display("FAIL poke_queued got done %0d busy %0d want 0 0", extra_done, extra_busy); end
    endtask

    task automatic test_back_to_back();
        do_run(4'd3, 10'd2, 10'd4, 6'h00, 1'b1, 0);
        target_idx  = 4'd8;
        observe_len = 10'd2;
        start       = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored got busy %b want 0", busy); end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if ({busy, cycle_count} !== {1'b1, 10'd1}) begin errors++; $display("FAIL b2b_accept got %b/%0d want 1/1", busy, cycle_count); end
        r_timeout = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (done) begin r_timeout = 1'b0; break; end
        end
        checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL b2b_done got timeout want done"); end
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        @(posedge clk);
        @(negedge clk);
        target_idx   = 4'd2;
        inject_cycle = 10'd3;
        observe_len  = 10'd10;
        golden_sig   = 6'h00;
        obs_in       = 3'b101;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({cycle_count, eqed_sel} !== {10'd3, 8'h04}) begin errors++; $display("FAIL rmr_pre got %0d/%h want 3/04", cycle_count, eqed_sel); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (eqed_sel !== 8'h00) begin errors++; $display("FAIL rmr_sel got %h want 00", eqed_sel); end
        checks++; if ({busy, injected, done, detected, sig_out, cycle_count} !== {4'b0000, 6'h01, 10'd0}) begin
            errors++; $display("FAIL rmr_outputs got %b%b%b%b/%h/%0d want 0000/01/0", busy, injected, done, detected, sig_out, cycle_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL rmr_no_done got %0d want 0", seen_done); end
    endtask

    task automatic test_random();
        logic [3:0] tgt;
        logic [9:0] len;
        logic [9:0] inj;
        logic [5:0] gold;
        logic [5:0] exp_sig;
        int         eff;
        bit         fl;
        for (int n = 0; n < 25; n++) begin
            tgt  = 4'($urandom_range(0, 15));
            len  = 10'($urandom_range(0, 30));
            inj  = 10'($urandom_range(0, int'(len) + 2));
            gold = 6'($urandom);
            do_run(tgt, inj, len, gold, 1'b1, 0);
            eff     = (len == 0) ? 1 : int'(len);
            fl      = model_flips(int'(tgt), int'(inj), eff);
            exp_sig = model_sig(eff);
            checks++; if (r_done_edge !== eff + 1) begin errors++; $display("FAIL rnd%0d_done_edge got %0d want %0d", n, r_done_edge, eff + 1); end
            checks++; if (r_sel_cycles !== (fl ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_flip_count got %0d want %0d", n, r_sel_cycles, fl ? 1 : 0); end
            if (fl) begin
                checks++; if ({r_sel_val, 10'(r_sel_cnt)} !== {8'(1 << tgt), inj}) begin
                    errors++; $display("FAIL rnd%0d_flip got %h@%0d want %h@%0d", n, r_sel_val, r_sel_cnt, 8'(1 << tgt), inj);
                end
            end
            checks++; if (r_inj !== fl) begin errors++; $display("FAIL rnd%0d_injected got %b want %b", n, r_inj, fl); end
            checks++; if (r_sig !== exp_sig) begin errors++; $display("FAIL rnd%0d_sig got %h want %h", n, r_sig, exp_sig); end
            checks++; if (r_det !== (exp_sig != gold)) begin errors++; $display("FAIL rnd%0d_det got %b want %b", n, r_det, exp_sig != gold); end
        end
    endtask

`ifdef EQED_SKIP_MASK_EN
    task automatic test_skip();
        skip_mask = 8'h20;
        do_run(4'd5, 10'd3, 10'd5, 6'h3f, 1'b1, 0);
        checks++; if (r_timeout || r_done_edge > 2) begin errors++; $display("FAIL skip_done_edge got %0d want <=2", r_done_edge); end
        checks++; if ({skipped, r_det, r_inj, r_sel_cycles != 0} !== 4'b1000) begin
            errors++; $display("FAIL skip_flags got %b%b%b%0d want 1000", skipped, r_det, r_inj, r_sel_cycles);
        end
        skip_mask = 8'h00;
    endtask
`endif

    initial begin
        start        = 1'b0;
        target_idx   = '0;
        inject_cycle = '0;
        observe_len  = '0;
        golden_sig   = '0;
        obs_in       = '0;
`ifdef EQED_SKIP_MASK_EN
        skip_mask    = '0;
`endif
        test_reset();
        test_signature();
        test_flip_timing();
        test_mismatch();
        test_out_of_window();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
`ifdef EQED_SKIP_MASK_EN
        test_skip();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
